// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_fifo_pkg;

   localparam int RXF_DEPTH_LOG2 = 4;
   localparam int RXF_THRESH     = 12;
   localparam int ERR_CNT_W      = 8;

   typedef logic [7:0]           rx_byte_t;
   typedef logic [ERR_CNT_W-1:0] err_cnt_t;

   localparam err_cnt_t ERR_CNT_MAX = '1;

   // Saturating increment: holds at ERR_CNT_MAX instead of wrapping to zero.
   function automatic err_cnt_t err_cnt_inc(input err_cnt_t c);
      return (c == ERR_CNT_MAX) ? c : c + err_cnt_t'(1);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FWFT FIFO: register array, wrapping pointers, occupancy counter.
// Latency: a push is visible on rdata/not_empty the next cycle; rdata is combinational from the head.
// Backpressure: push while full is refused unless a pop happens the same cycle; flush discards both.
module uart_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  not_empty
);

   localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [0:(1<<DEPTH_LOG2)-1];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  pop_ok, push_ok;

   // Full/empty come from the occupancy counter, so equal pointers are never ambiguous.
   assign not_empty = (level_q != '0);
   assign full      = (level_q == DEPTH);
   assign pop_ok    = pop & not_empty & ~flush;
   assign push_ok   = push & ~flush & (~full | pop_ok);
   assign rdata     = not_empty ? mem_q[rd_ptr_q] : '0;
   assign level     = level_q;

   // Next pointer/level state; flush clears everything and drops any same-cycle traffic.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         if (push_ok && !pop_ok)      level_d = level_q + (DEPTH_LOG2+1)'(1);
         else if (pop_ok && !push_ok) level_d = level_q - (DEPTH_LOG2+1)'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; entries need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (rst_n && push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one FIFO push per rx_done assertion, error counting, sticky overflow.
// Latency: byte visible on out_valid/out_data one cycle after the rx_done rising edge.
// Backpressure: FWFT valid/ready to the host; a byte arriving at a full FIFO with no pop is dropped and sets overflow.
// Optional: define UART_RX_FIFO_LEVEL_IRQ_EN to add the registered level_irq output.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = RXF_DEPTH_LOG2,
   parameter int THRESH     = RXF_THRESH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_done,
   input  logic                  rx_err,
   input  logic [7:0]            rx_data,
   input  logic                  flush,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [7:0]            out_data,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  clr_status,
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
   output logic                  level_irq,
`endif
   output logic [7:0]            err_count
);

   logic     done_q, err_q;
   logic     overflow_q, overflow_d;
   err_cnt_t err_count_q, err_count_d;
   logic     push_stb, err_stb, pop, fifo_full;
   rx_byte_t fifo_rdata;

   assign push_stb = rx_done & ~done_q;
   assign err_stb  = rx_err & ~err_q;
   assign pop      = out_valid & out_ready;

   uart_sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push_stb),
      .pop       (pop),
      .wdata     (rx_data),
      .rdata     (fifo_rdata),
      .level     (level),
      .full      (fifo_full),
      .not_empty (out_valid)
   );

   assign out_data  = fifo_rdata;
   assign overflow  = overflow_q;
   assign err_count = err_count_q;

   // Status next-state: a new event in the clear cycle wins over the clear.
   always_comb begin
      overflow_d  = overflow_q;
      err_count_d = err_count_q;
      if (push_stb && fifo_full && !pop && !flush) overflow_d = 1'b1;
      else if (clr_status)                         overflow_d = 1'b0;
      if (err_stb) err_count_d = clr_status ? err_cnt_t'(1) : err_cnt_inc(err_count_q);
      else if (clr_status) err_count_d = '0;
   end

   // Edge detectors reset high so a level already asserted at reset release is ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_q      <= 1'b1;
         err_q       <= 1'b1;
         overflow_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         done_q      <= rx_done;
         err_q       <= rx_err;
         overflow_q  <= overflow_d;
         err_count_q <= err_count_d;
      end
   end

`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
   logic level_irq_q, level_irq_d;

   assign level_irq = level_irq_q;

   // Threshold flag follows the occupancy one cycle later; flush forces it low.
   always_comb begin
      level_irq_d = flush ? 1'b0 : (level >= (DEPTH_LOG2+1)'(THRESH));
   end

   // Registered threshold flag.
   always_ff @(posedge clk) begin
      if (!rst_n) level_irq_q <= 1'b0;
      else        level_irq_q <= level_irq_d;
   end
`else
   localparam int unused_thresh = THRESH;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
// Latency: outputs are compared every cycle, 1 time unit after the rising edge.
// Backpressure: out_ready is driven randomly and in directed bursts.
module tb_uart_rx_fifo;

   localparam int DL2    = 4;
   localparam int DEPTH  = 16;
   localparam int THRESH = 12;

   logic           clk;
   logic           rst_n;
   logic           rx_done;
   logic           rx_err;
   logic [7:0]     rx_data;
   logic           flush;
   logic           out_ready;
   logic           out_valid;
   logic [7:0]     out_data;
   logic [DL2:0]   level;
   logic           overflow;
   logic           clr_status;
   logic [7:0]     err_count;
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
   logic           level_irq;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [7:0] mq[$];
   logic       m_ovf;
   int         m_ec;
   logic       m_pd, m_pe;
   logic       m_irq;

   uart_rx_fifo #(.DEPTH_LOG2(DL2), .THRESH(THRESH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_done    (rx_done),
      .rx_err     (rx_err),
      .rx_data    (rx_data),
      .flush      (flush),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .level      (level),
      .overflow   (overflow),
      .clr_status (clr_status),
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
      .level_irq  (level_irq),
`endif
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_ec  = 0;
      m_pd  = 1'b1;
      m_pe  = 1'b1;
      m_irq = 1'b0;
   endtask

   // One clock of the behavioural model, using the inputs currently driven.
   task automatic model_update();
      logic push, estb, pop, drop;
      int   sz;
      if (!rst_n) begin
         model_reset();
         return;
      end
      sz   = mq.size();
      push = rx_done && !m_pd;
      estb = rx_err && !m_pe;
      pop  = (sz > 0) && out_ready;
      drop = 1'b0;
      if (flush) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (sz < DEPTH || pop) mq.push_back(rx_data);
            else drop = 1'b1;
         end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_status) m_ovf = 1'b0;
      if (estb) m_ec = clr_status ? 1 : ((m_ec < 255) ? m_ec + 1 : 255);
      else if (clr_status) m_ec = 0;
      m_irq = flush ? 1'b0 : (sz >= THRESH);
      m_pd  = rx_done;
      m_pe  = rx_err;
   endtask

   // Compare all outputs with the model, then advance one clock.
   task automatic step();
      chk("out_valid", out_valid, (mq.size() != 0));
      chk("out_data",  out_data,  (mq.size() != 0) ? mq[0] : 8'h00);
      chk("level",     level,     mq.size());
      chk("overflow",  overflow,  m_ovf);
      chk("err_count", err_count, m_ec);
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
      chk("level_irq", level_irq, m_irq);
`endif
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      rx_done = 1'b1;
      rx_data = b;
      repeat (hold) step();
      rx_done = 1'b0;
      repeat (gap) step();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (DEPTH + 1) step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
      flush = 1'b0; out_ready = 1'b0; clr_status = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      // reset state
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data",  out_data, 0);
      chk("rst_ovf",   overflow, 0);
      chk("rst_ec",    err_count, 0);
      rst_n = 1'b1;
      step();

      // one push per 16-cycle rx_done
      rx_done = 1'b1; rx_data = 8'hA5;
      step();
      chk("a5_level", level, 1);
      chk("a5_data",  out_data, 8'hA5);
      repeat (15) step();
      rx_done = 1'b0;
      chk("a5_single", level, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("a5_pop", level, 0);

      // fill to full, then overflow, then drain in order across the wrap
      for (int i = 0; i < 16; i++) send_byte(8'(i), 3, 1);
      send_byte(8'h10, 2, 1);
      chk("full_level", level, 16);
      chk("full_ovf",   overflow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("fill_order", out_data, i);
         step();
      end
      out_ready = 1'b0;
      chk("fill_empty", level, 0);

      // full FIFO with simultaneous push and pop
      clr_status = 1'b1; step(); clr_status = 1'b0;
      chk("clr_ovf", overflow, 0);
      for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 2, 1);
      rx_done = 1'b1; rx_data = 8'h55; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pp_ovf",   overflow, 0);
      chk("pp_level", level, 16);
      repeat (3) step();
      rx_done = 1'b0;
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("pp_last", out_data, 8'h55);
         step();
      end
      out_ready = 1'b0;

      // err_count saturation and clear-vs-event priority
      for (int i = 0; i < 300; i++) begin
         rx_err = 1'b1; step();
         rx_err = 1'b0; step();
      end
      chk("ec_sat", err_count, 255);
      rx_err = 1'b1; clr_status = 1'b1;
      step();
      rx_err = 1'b0; clr_status = 1'b0;
      chk("ec_clr_evt", err_count, 1);
      step();

      // flush coincident with a push
      for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 2, 1);
      chk("fl_pre", level, 5);
      rx_done = 1'b1; rx_data = 8'h77; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_level", level, 0);
      chk("fl_valid", out_valid, 0);
      repeat (4) step();
      chk("fl_nopush", level, 0);
      rx_done = 1'b0;
      step();

      // reset while rx_done is high
      send_byte(8'h81, 2, 1);
      send_byte(8'h82, 2, 1);
      rx_done = 1'b1; rx_data = 8'h83; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("rst_nopush", level, 0);
      rx_done = 1'b0;
      step();
      send_byte(8'h99, 2, 1);
      chk("rst_fresh", level, 1);
      chk("rst_fresh_d", out_data, 8'h99);
      drain();

`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
      for (int i = 0; i < 11; i++) send_byte(8'(i), 1, 1);
      rx_done = 1'b1; rx_data = 8'hC0;
      step();
      chk("irq_lag", level_irq, 0);
      rx_done = 1'b0;
      step();
      chk("irq_set", level_irq, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("irq_hold", level_irq, 1);
      step();
      chk("irq_clr", level_irq, 0);
      drain();
`endif

      // randomized traffic
      for (int blk = 0; blk < 20; blk++) begin
         int rdy_pct;
         rdy_pct = $urandom_range(5, 95);
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 3) == 0) rx_done = ~rx_done;
            if ($urandom_range(0, 3) == 0) rx_err = ~rx_err;
            rx_data    = 8'($urandom);
            out_ready  = ($urandom_range(0, 99) < rdy_pct);
            flush      = ($urandom_range(0, 63) == 0);
            clr_status = ($urandom_range(0, 49) == 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            step();
         end
      end
      rst_n = 1'b1; flush = 1'b0; clr_status = 1'b0; out_ready = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
